// File: rtl/sccb_pkg.sv
// Shared definitions for the SCCB masters.
// Contents: FSM state type, bit/ACK positions within a three-byte write, quarter-phase
// encodings and a helper that classifies a bit index as an ACK slot.
package sccb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StBit,
    StStop
  } sccb_state_e;

  // Bits on the wire per write: 3 x (8 data + 1 ACK).
  localparam int unsigned NBits   = 27;
  localparam logic [4:0]  LastBit = 5'(NBits - 1);

  // Bit indices where the slave drives ACK and the master releases SIOD.
  localparam logic [4:0] AckBit0 = 5'd8;
  localparam logic [4:0] AckBit1 = 5'd17;
  localparam logic [4:0] AckBit2 = 5'd26;

  // Quarter-bit phases.
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  function automatic logic is_ack_bit(input logic [4:0] b);
    return (b == AckBit0) || (b == AckBit1) || (b == AckBit2);
  endfunction

endpackage

// File: rtl/sccb_tick_edge.sv
// Rising-edge detector for the divided quarter-bit wave.
// Ports:
//   clk_in  - system clock (same clock as the upstream divider)
//   reset   - asynchronous active-high reset
//   tick_in - divided square wave, already a flop output in this domain
//   tick    - one-cycle pulse on each rising edge of tick_in
module sccb_tick_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic tick_in,
  output logic tick
);

  logic tick_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_in;
    end
  end

  // tick_in comes from a same-domain flop, so no synchroniser is needed.
  assign tick = tick_in & ~tick_q;

endmodule

// File: rtl/sccb_write_master.sv
// Three-phase SCCB write master: writes one data byte to one camera register.
// Every bus transition happens on a quarter-bit tick derived from tick_in; tick_in is a
// timing reference only, never a clock.
// Ports:
//   clk_in   - system clock
//   reset    - asynchronous active-high reset
//   tick_in  - divided square wave; each rising edge is one quarter-bit
//   start    - request, sampled only while idle
//   id       - device ID including write bit
//   addr     - register address
//   data     - register value
//   siod_in  - SIOD pad readback (used for ACK)
//   sioc     - SCCB clock line
//   siod_out - SIOD drive value
//   siod_oe  - 1 = drive siod_out, 0 = release SIOD
//   busy     - transaction in progress
//   done     - one-cycle pulse at end of transaction
//   nack     - sticky ACK failure of the last transaction
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter bit          IGNORE_NACK = 1'b0,
  parameter int unsigned BYTES       = 3
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       start,
  input  logic [7:0] id,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic       siod_in,
  output logic       sioc,
  output logic       siod_out,
  output logic       siod_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  localparam int unsigned ShiftW = BYTES * 8;

  logic              tick;
  sccb_state_e       state_q;
  logic [1:0]        quarter_q;
  logic [4:0]        bit_q;
  logic [ShiftW-1:0] shift_q;
  logic              ack_slot;

  sccb_tick_edge u_tick_edge (
    .clk_in  (clk_in),
    .reset   (reset),
    .tick_in (tick_in),
    .tick    (tick)
  );

  assign ack_slot = is_ack_bit(bit_q);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      quarter_q <= Q0;
      bit_q     <= 5'd0;
      shift_q   <= '0;
      sioc      <= 1'b1;
      siod_out  <= 1'b1;
      siod_oe   <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          sioc     <= 1'b1;
          siod_out <= 1'b1;
          siod_oe  <= 1'b1;
          busy     <= 1'b0;
          if (start) begin
            shift_q   <= {id, addr, data};
            nack      <= 1'b0;
            busy      <= 1'b1;
            quarter_q <= Q0;
            state_q   <= StStart;
          end
        end

        StStart: begin
          if (tick) begin
            if (quarter_q == Q0) begin
              // SIOD falls while SIOC is high: start condition.
              siod_out  <= 1'b0;
              quarter_q <= Q1;
            end else begin
              sioc      <= 1'b0;
              quarter_q <= Q0;
              bit_q     <= 5'd0;
              state_q   <= StBit;
            end
          end
        end

        StBit: begin
          if (tick) begin
            quarter_q <= quarter_q + 2'd1;
            unique case (quarter_q)
              Q0: begin
                if (ack_slot) begin
                  siod_oe  <= 1'b0;
                  siod_out <= 1'b1;
                end else begin
                  siod_oe  <= 1'b1;
                  siod_out <= shift_q[ShiftW-1];
                end
              end
              Q1: sioc <= 1'b1;
              Q2: begin
                if (ack_slot && !IGNORE_NACK && siod_in) begin
                  nack <= 1'b1;
                end
              end
              Q3: begin
                sioc <= 1'b0;
                if (!ack_slot) begin
                  shift_q <= shift_q << 1;
                end
                // bit_q stops at LastBit; it never wraps.
                if (bit_q == LastBit) begin
                  state_q <= StStop;
                end else begin
                  bit_q <= bit_q + 5'd1;
                end
              end
              default: ;
            endcase
          end
        end

        StStop: begin
          if (tick) begin
            unique case (quarter_q)
              Q0: begin
                siod_oe   <= 1'b1;
                siod_out  <= 1'b0;
                quarter_q <= Q1;
              end
              Q1: begin
                sioc      <= 1'b1;
                quarter_q <= Q2;
              end
              Q2: begin
                // SIOD rises while SIOC is high: stop condition, transaction complete.
                siod_out  <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
                quarter_q <= Q0;
                state_q   <= StIdle;
              end
              default: quarter_q <= Q0;
            endcase
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sccb_write_master.sv
module tb_sccb_write_master;

  logic       clk_in = 1'b0;
  logic       reset = 1'b1;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic [7:0] id = 8'h00;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic       siod_in = 1'b0;

  logic sioc, siod_out, siod_oe, busy, done, nack;
  logic sioc1, siod_out1, siod_oe1, busy1, done1, nack1;

  int checks = 0;
  int errors = 0;

  // Upstream divider model.
  int half = 2;
  logic tick_run = 1'b1;
  int div_cnt = 0;

  // ACK responder controls.
  logic [2:0] resp_mask = 3'b000;
  logic       hold_one = 1'b0;

  sccb_write_master #(.IGNORE_NACK(1'b0)) dut0 (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .start(start), .id(id), .addr(addr),
    .data(data), .siod_in(siod_in), .sioc(sioc), .siod_out(siod_out), .siod_oe(siod_oe),
    .busy(busy), .done(done), .nack(nack)
  );

  sccb_write_master #(.IGNORE_NACK(1'b1)) dut1 (
    .clk_in(clk_in), .reset(reset), .tick_in(tick_in), .start(start), .id(id), .addr(addr),
    .data(data), .siod_in(siod_in), .sioc(sioc1), .siod_out(siod_out1), .siod_oe(siod_oe1),
    .busy(busy1), .done(done1), .nack(nack1)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (tick_run) begin
      if (div_cnt >= half - 1) begin
        div_cnt <= 0;
        tick_in <= ~tick_in;
      end else begin
        div_cnt <= div_cnt + 1;
      end
    end
  end

  // Bus monitor: records the line value at each SIOC rise and summarises each transaction.
  logic vals[27];
  logic oes[27];
  int   rise_cnt = 0, tick_cnt = 0, ack_cnt = 0, start_cond = 0, stop_cond = 0;
  int   done_cnt = 0, wave_diff = 0;
  logic prev_busy = 1'b0, prev_tick = 1'b0, prev_sioc = 1'b1, prev_out = 1'b1, prev_oe = 1'b1;
  logic [7:0]  snap_b0, snap_b1, snap_b2;
  logic [26:0] snap_oe;
  int   snap_ticks, snap_rises, snap_start, snap_stop;
  logic snap_nack0, snap_nack1, snap_busy;

  always @(negedge clk_in) begin
    if (busy && !prev_busy) begin
      rise_cnt = 0; tick_cnt = 0; ack_cnt = 0; start_cond = 0; stop_cond = 0;
      for (int i = 0; i < 27; i++) begin
        vals[i] = 1'b0;
        oes[i] = 1'b0;
      end
    end
    if (busy && tick_in && !prev_tick) tick_cnt++;
    if (busy && sioc && !prev_sioc) begin
      if (rise_cnt < 27) begin
        vals[rise_cnt] = siod_out;
        oes[rise_cnt] = siod_oe;
      end
      rise_cnt++;
    end
    if (!siod_oe && prev_oe) ack_cnt++;
    if (sioc && prev_sioc && siod_oe && prev_out && !siod_out) start_cond++;
    if (sioc && prev_sioc && siod_oe && !prev_out && siod_out) stop_cond++;
    if ({sioc, siod_out, siod_oe, busy, done} !== {sioc1, siod_out1, siod_oe1, busy1, done1})
      wave_diff++;
    if (done) begin
      done_cnt++;
      snap_b0 = 8'h00; snap_b1 = 8'h00; snap_b2 = 8'h00;
      for (int i = 0; i < 8; i++) begin
        snap_b0 = {snap_b0[6:0], vals[i]};
        snap_b1 = {snap_b1[6:0], vals[9+i]};
        snap_b2 = {snap_b2[6:0], vals[18+i]};
      end
      for (int i = 0; i < 27; i++) snap_oe[i] = oes[i];
      snap_ticks = tick_cnt; snap_rises = rise_cnt;
      snap_start = start_cond; snap_stop = stop_cond;
      snap_nack0 = nack; snap_nack1 = nack1; snap_busy = busy;
    end
    siod_in = hold_one | (!siod_oe && ack_cnt >= 1 && ack_cnt <= 3 && resp_mask[ack_cnt-1]);
    prev_busy = busy; prev_tick = tick_in; prev_sioc = sioc; prev_out = siod_out;
    prev_oe = siod_oe;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bit i of a write is released for ACK when it is the ninth bit of its byte.
  function automatic logic [26:0] drive_mask();
    logic [26:0] m;
    for (int i = 0; i < 27; i++) m[i] = ((i % 9) != 8);
    return m;
  endfunction

  task automatic do_start(input string tag, input logic [7:0] i, input logic [7:0] a,
                          input logic [7:0] d);
    @(negedge clk_in);
    id = i; addr = a; data = d; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    #1;
    chk({tag, "_accept_busy"}, 32'(busy), 32'd1);
    chk({tag, "_nack_cleared"}, 32'(nack), 32'd0);
  endtask

  task automatic wait_done(input string tag, input int n0);
    int k = 0;
    while (done_cnt == n0 && k < 5000) begin
      @(negedge clk_in);
      #1;
      k++;
    end
    chk({tag, "_done_seen"}, 32'(done_cnt != n0), 32'd1);
  endtask

  task automatic check_txn(input string tag, input logic [7:0] i, input logic [7:0] a,
                           input logic [7:0] d, input logic exp_nack, input logic busy_next);
    chk({tag, "_id"}, 32'(snap_b0), 32'(i));
    chk({tag, "_addr"}, 32'(snap_b1), 32'(a));
    chk({tag, "_data"}, 32'(snap_b2), 32'(d));
    chk({tag, "_oe_mask"}, 32'(snap_oe), 32'(drive_mask()));
    chk({tag, "_ticks"}, 32'(snap_ticks), 32'd113);
    chk({tag, "_sioc_rises"}, 32'(snap_rises), 32'd28);
    chk({tag, "_start_stop"}, 32'({snap_start[3:0], snap_stop[3:0]}), 32'h11);
    chk({tag, "_nack"}, 32'(snap_nack0), 32'(exp_nack));
    chk({tag, "_nack_ignored"}, 32'(snap_nack1), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(snap_busy), 32'd0);
    @(negedge clk_in);
    #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, "_busy_after"}, 32'(busy), 32'(busy_next));
  endtask

  initial begin
    int bad;
    int n0;
    int k;
    logic [5:0] frz;
    logic [7:0] ri, ra, rd;
    logic [2:0] rr;

    // 1: reset state and quiet idle.
    repeat (3) @(negedge clk_in);
    #1;
    chk("reset_outputs", 32'({sioc, siod_out, siod_oe, busy, done, nack}), 32'b111000);
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk_in);
      #1;
      if ({sioc, siod_out, siod_oe, busy, done, nack} !== 6'b111000) bad++;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    // 2: nominal write, all ACKs good.
    half = 2; resp_mask = 3'b000;
    n0 = done_cnt;
    do_start("s2", 8'h42, 8'h12, 8'h80);
    wait_done("s2", n0);
    check_txn("s2", 8'h42, 8'h12, 8'h80, 1'b0, 1'b0);

    // 3: NACK on the second ACK slot only; cleared by the next start.
    resp_mask = 3'b010;
    n0 = done_cnt;
    do_start("s3", 8'h42, 8'h12, 8'h80);
    wait_done("s3", n0);
    check_txn("s3", 8'h42, 8'h12, 8'h80, 1'b1, 1'b0);
    chk("s3_nack_sticky", 32'(nack), 32'd1);

    // 4: siod_in held high; the IGNORE_NACK instance must match the waveform exactly.
    resp_mask = 3'b000; hold_one = 1'b1;
    n0 = done_cnt;
    do_start("s4", 8'h42, 8'h12, 8'h80);
    wait_done("s4", n0);
    check_txn("s4", 8'h42, 8'h12, 8'h80, 1'b1, 1'b0);
    hold_one = 1'b0;
    chk("s4_wave_identical", 32'(wave_diff), 32'd0);

    // Randomised writes against the monitor's bus decode.
    for (int t = 0; t < 4; t++) begin
      half = int'($urandom_range(1, 3));
      ri = {7'($urandom), 1'b0}; ra = 8'($urandom); rd = 8'($urandom); rr = 3'($urandom);
      resp_mask = rr;
      n0 = done_cnt;
      do_start($sformatf("rnd%0d", t), ri, ra, rd);
      wait_done($sformatf("rnd%0d", t), n0);
      check_txn($sformatf("rnd%0d", t), ri, ra, rd, |rr, 1'b0);
    end
    resp_mask = 3'b000;

    // 5: reset pulse at tick 50, then a clean transaction.
    half = 2;
    do_start("s5a", 8'h5a, 8'ha5, 8'h3c);
    k = 0;
    while (tick_cnt < 50 && k < 2000) begin
      @(negedge clk_in);
      #1;
      k++;
    end
    chk("s5_reached_tick50", 32'(tick_cnt), 32'd50);
    reset = 1'b1;
    #1;
    chk("s5_async_reset", 32'({sioc, siod_out, siod_oe, busy, done, nack}), 32'b111000);
    chk("s5_async_reset_ign", 32'({sioc1, siod_out1, siod_oe1, busy1, done1, nack1}),
        32'b111000);
    @(negedge clk_in);
    reset = 1'b0;
    n0 = done_cnt;
    do_start("s5", 8'h60, 8'h3a, 8'hc7);
    wait_done("s5", n0);
    check_txn("s5", 8'h60, 8'h3a, 8'hc7, 1'b0, 1'b0);

    // 6: start held high, tick frozen at bit 10, then back-to-back second write.
    @(negedge clk_in);
    id = 8'h78; addr = 8'h0f; data = 8'hf0; start = 1'b1;
    @(negedge clk_in);
    #1;
    chk("s6_accept_busy", 32'(busy), 32'd1);
    n0 = done_cnt;
    id = 8'h30; addr = 8'hc3; data = 8'h69;
    k = 0;
    while (rise_cnt != 11 && k < 2000) begin
      @(negedge clk_in);
      #1;
      k++;
    end
    chk("s6_reached_bit10", 32'(rise_cnt), 32'd11);
    tick_run = 1'b0;
    repeat (2) @(negedge clk_in);
    #1;
    frz = {sioc, siod_out, siod_oe, busy, done, nack};
    bad = 0;
    repeat (200) begin
      @(negedge clk_in);
      #1;
      if ({sioc, siod_out, siod_oe, busy, done, nack} !== frz) bad++;
    end
    chk("s6_frozen", 32'(bad), 32'd0);
    chk("s6_frozen_busy", 32'(busy), 32'd1);
    tick_run = 1'b1;
    wait_done("s6a", n0);
    check_txn("s6a", 8'h78, 8'h0f, 8'hf0, 1'b0, 1'b1);
    start = 1'b0;
    n0 = done_cnt;
    wait_done("s6b", n0);
    check_txn("s6b", 8'h30, 8'hc3, 8'h69, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_write_master.md
Name: sccb_write_master

Overview:
- Three-phase SCCB (I2C-like) write master for camera register configuration.
- Sits directly downstream of the clock-divider stage. It consumes the divided square wave as a timing reference; that wave is not used as a clock.
- Each accepted request writes one byte (data) to one camera register (addr) at a device ID (id).
- Drives SIOC and SIOD through an open-drain-style enable; pad and tristate logic live outside this block.

Parameters:
- IGNORE_NACK, 0, when 1 the nack output is held at 0 and ACK sampling is skipped.
- BYTES, 3, number of bytes per transaction: ID, register address, data. Fixed; the parameter exists for lint and documentation only.

Ports:
- clk_in  input  1  system clock, the same clock that drives the divider.
- reset  input  1  asynchronous, active-high reset.
- tick_in  input  1  divided square wave from the upstream divider; each rising edge is one quarter-bit.
- start  input  1  request; sampled only in IDLE.
- id  input  8  SCCB device ID, including the write bit (LSB = 0).
- addr  input  8  camera register address.
- data  input  8  value to write.
- siod_in  input  1  SIOD pad readback.
- sioc  output  1  SCCB clock line.
- siod_out  output  1  SIOD drive value.
- siod_oe  output  1  1 = drive siod_out; 0 = release the line (ACK/don't-care bit).
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse at the end of a transaction.
- nack  output  1  ACK check failed during the last transaction (sticky until the next accepted start).

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - State returns to IDLE.
  - sioc=1, siod_out=1, siod_oe=1, busy=0, done=0, nack=0.
  - The tick edge register clears to 0.
- Tick: tick = tick_in & ~tick_q, with tick_q registered on clk_in. tick_in is a flop output in the same domain, so no synchroniser is needed. All bus activity advances only on tick cycles.
- IDLE:
  - Bus lines are held high.
  - When start=1, latch {id, addr, data} into a 24-bit shift register, clear nack, set busy=1 on the next edge, and go to START with quarter counter q=0.
  - The latched inputs are don't-care afterwards.
  - start is ignored while not in IDLE.
- START (2 ticks):
  - q0: siod_out=0 (sioc still 1).
  - q1: sioc=0. Then go to BIT with bit index b=0.
- BIT, 27 bits (b=0..26), 4 ticks each:
  - q0: set the SIOD value, sioc stays 0.
  - q1: sioc=1.
  - q2: hold; sample siod_in if this is an ACK bit.
  - q3: sioc=0. b increments, or the machine goes to STOP after b=26.
- Data bits: b not in {8, 17, 26}. siod_oe=1 and siod_out = shift-register MSB. The register shifts left at q3.
- ACK bits: b = 8, 17, 26. siod_oe=0 from q0 through q3. At q2, if siod_in=1 and IGNORE_NACK=0, set nack=1. siod_oe returns to 1 at q0 of the next phase.
- STOP (3 ticks):
  - q0: siod_oe=1, siod_out=0.
  - q1: sioc=1.
  - q2: siod_out=1. Go to IDLE.
- Completion cycle:
  - done=1 for exactly that one clk_in cycle, and busy=0 in the same cycle.
  - A start present in the cycle after IDLE is entered is accepted normally (back-to-back transactions).
- Latency:
  - Exactly 113 ticks from the first tick after start acceptance to done (2 + 108 + 3).
  - done rises one clk_in cycle after the 113th tick edge is registered.
- Stalled timing: if tick_in stops toggling, the machine holds its state indefinitely with outputs frozen. There is no timeout.
- Counter widths: q is 2 bits and b is 5 bits. b never exceeds 26, and no wrap-around beyond the terminal value is allowed.

Decomposition:
- Shared package sccb_pkg:
  - state enum {IDLE, START, BIT, STOP}.
  - N_BITS = 27.
  - ACK positions 8, 17, 26.
  - Quarter-phase constants.
- Sub-module sccb_tick_edge: the rising-edge detector on tick_in, with asynchronous active-high reset. It is reusable by a future SCCB read master.

Test Plan:
1. Reset release, then 20 cycles with no start → sioc=1, siod_out=1, siod_oe=1, busy=0, done=0.
2. tick_in from a divider at 4 cycles/tick, start with id=0x42, addr=0x12, data=0x80, siod_in tied 0 → decoded bytes on SIOC rising edges are 0x42, 0x12, 0x80; siod_oe=0 exactly during bits 8, 17, 26; done pulses once after 113 ticks; nack=0.
3. Same stimulus with siod_in=1 during the second ACK bit only → nack=1 after done. nack clears on the next accepted start.
4. Same stimulus with IGNORE_NACK=1 and siod_in held 1 → nack stays 0; waveform identical to scenario 2.
5. Assert reset for 1 cycle at tick 50 (mid data byte) → all outputs return to reset values immediately. A new start after reset produces a full, correct 113-tick transaction.
6. start held high continuously, and tick_in frozen for 200 cycles at bit 10 → start has no effect mid-transaction and outputs stay frozen while tick_in is frozen. Back-to-back: a second transaction begins in the cycle after done, with no extra idle tick required.
